// File: rtl/pool_layer_engine_pkg.sv
// Shared types, state encodings and bank-select helpers for the pooling engine.
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  // FSM state encoding, shared so that a debug view of the state can be decoded.
  typedef logic [2:0] pool_state_t;
  localparam pool_state_t ST_IDLE   = 3'd0;
  localparam pool_state_t ST_SEL_CH = 3'd1;
  localparam pool_state_t ST_READ   = 3'd2;
  localparam pool_state_t ST_FLUSH  = 3'd3;
  localparam pool_state_t ST_WRITE  = 3'd4;
  localparam pool_state_t ST_NEXT   = 3'd5;
  localparam pool_state_t ST_FIN    = 3'd6;

  // Source bank select of a channel.
  function automatic int unsigned sel_l0(input int unsigned base, input int unsigned ch);
    return base + ch;
  endfunction

  // Destination bank select of a channel.
  function automatic int unsigned sel_l1(input int unsigned base, input int unsigned ch);
    return base + ch;
  endfunction

endpackage

// File: rtl/pool_layer_engine_reduce.sv
// Four-sample window reducer: running unsigned max, or sum with round-half-up average.
module pool_reduce
  import pool_pkg::*;
#(
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              valid_i,
  input  pool_mode_e        mode_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] result_o
);

  // Two extra bits hold the sum of four samples without overflow.
  logic [DATA_W+1:0] acc_q, acc_d, rounded;
  logic [DATA_W+1:0] data_ext;

  assign data_ext = {2'b00, data_i};

  // Fold one sample per valid cycle; zero is the identity for both max and sum.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (valid_i) begin
      if (mode_i == POOL_AVG) begin
        acc_d = acc_q + data_ext;
      end else if (data_ext > acc_q) begin
        acc_d = data_ext;
      end
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  // (sum + 2) >> 2 rounds half up; all-ones input still yields all-ones.
  assign rounded  = acc_q + (DATA_W + 2)'(2);
  assign result_o = (mode_i == POOL_AVG) ? rounded[DATA_W+1:2] : acc_q[DATA_W-1:0];

endmodule

// File: rtl/pool_layer_engine.sv
// 2x2 pooling engine: walks each enabled channel's layer-0 bank window by window
// and writes one reduced value per window into that channel's layer-1 bank.
// Handshake: crd/caddr_rd issue a read whose data arrives on cdata_rd exactly one
// cycle later; cwr/caddr_wr/cdata_wr are a one-cycle write with no back-pressure.
module pool_layer_engine
  import pool_pkg::*;
#(
  parameter int IMG_W       = 64,
  parameter int DATA_W      = 20,
  parameter int NUM_CH      = 2,
  parameter int SEL_W       = 3,
  parameter int L0_SEL_BASE = 1,
  parameter int L1_SEL_BASE = 3,
  parameter int ADDR_W      = $clog2(IMG_W * IMG_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pool_mode,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              busy,
  output logic              done,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [DATA_W-1:0] cdata_wr,
  output logic [SEL_W-1:0]  csel,
  output logic [2:0]        state_o
);

  localparam int HALF = IMG_W / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  pool_state_t       state_q, state_d;
  pool_mode_e        mode_q, mode_d;
  logic [NUM_CH-1:0] pend_q, pend_d, low_onehot;
  logic [CHW-1:0]    ch_q, ch_d, low_ch;
  logic [CW-1:0]     r_q, r_d, c_q, c_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] caddr_rd_q, caddr_wr_q;
  logic [DATA_W-1:0] cdata_wr_q, red_result;
  logic              red_clear, red_valid;

  // Lowest channel still pending in this run.
  assign low_onehot = pend_q & (~pend_q + NUM_CH'(1));
  always_comb begin
    low_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_q[i]) low_ch = CHW'(i);
    end
  end

  // Next-state logic: channel select, 4 reads, flush, write, advance window.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pend_d  = pend_q;
    ch_d    = ch_q;
    r_d     = r_q;
    c_d     = c_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEL_CH;
          mode_d  = pool_mode_e'(pool_mode);
          pend_d  = ch_mask;
        end
      end
      ST_SEL_CH: begin
        if (|pend_q) begin
          ch_d    = low_ch;
          pend_d  = pend_q & ~low_onehot;
          r_d     = '0;
          c_d     = '0;
          idx_d   = '0;
          state_d = ST_READ;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_READ: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = ST_FLUSH;
      end
      ST_FLUSH: state_d = ST_WRITE;
      ST_WRITE: state_d = ST_NEXT;
      ST_NEXT: begin
        state_d = ST_READ;
        if (c_q == CW'(HALF - 1)) begin
          c_d = '0;
          if (r_q == CW'(HALF - 1)) state_d = ST_SEL_CH;
          else                      r_d     = r_q + CW'(1);
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops straight to IDLE with quiet outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= POOL_MAX;
      pend_q     <= '0;
      ch_q       <= '0;
      r_q        <= '0;
      c_q        <= '0;
      idx_q      <= '0;
      caddr_rd_q <= '0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      pend_q     <= pend_d;
      ch_q       <= ch_d;
      r_q        <= r_d;
      c_q        <= c_d;
      idx_q      <= idx_d;
      caddr_rd_q <= caddr_rd;
      caddr_wr_q <= caddr_wr;
      cdata_wr_q <= cdata_wr;
    end
  end

  // Idx 0 starts a window; data of the previous idx is folded one cycle behind its read.
  assign red_clear = (state_q == ST_READ) && (idx_q == 2'd0);
  assign red_valid = ((state_q == ST_READ) && (idx_q != 2'd0)) || (state_q == ST_FLUSH);

  pool_reduce #(.DATA_W(DATA_W)) u_reduce (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (red_clear),
    .valid_i  (red_valid),
    .mode_i   (mode_q),
    .data_i   (cdata_rd),
    .result_o (red_result)
  );

  // Strobes decode from state; addresses and write data hold their last value when idle.
  assign busy     = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done     = (state_q == ST_FIN);
  assign crd      = (state_q == ST_READ);
  assign cwr      = (state_q == ST_WRITE);
  assign state_o  = state_q;
  assign caddr_rd = crd ? ADDR_W'((2 * int'(r_q) + int'(idx_q[1])) * IMG_W
                                  + 2 * int'(c_q) + int'(idx_q[0]))
                        : caddr_rd_q;
  assign caddr_wr = cwr ? ADDR_W'(int'(r_q) * HALF + int'(c_q)) : caddr_wr_q;
  assign cdata_wr = cwr ? red_result : cdata_wr_q;
  assign csel     = crd ? SEL_W'(sel_l0(L0_SEL_BASE, ch_q)) :
                    cwr ? SEL_W'(sel_l1(L1_SEL_BASE, ch_q)) : '0;

endmodule

// File: tb/tb_pool_layer_engine.sv
// Bench for pool_layer_engine: bank memory model, window-level reference model,
// write scoreboard and per-run timing checks.
module tb_pool_layer_engine;

  localparam int IMG_W  = 4;
  localparam int DATA_W = 20;
  localparam int NUM_CH = 2;
  localparam int SEL_W  = 3;
  localparam int L0     = 1;
  localparam int L1     = 3;
  localparam int ADDR_W = 4;
  localparam int HALF   = IMG_W / 2;
  localparam int NPIX   = IMG_W * IMG_W;
  localparam int W      = SEL_W + ADDR_W + DATA_W;
  localparam logic [DATA_W-1:0] ONES = '1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              pool_mode;
  logic [NUM_CH-1:0] ch_mask;
  logic              busy, done, crd, cwr;
  logic [ADDR_W-1:0] caddr_rd, caddr_wr;
  logic [DATA_W-1:0] cdata_rd = '0;
  logic [DATA_W-1:0] cdata_wr;
  logic [SEL_W-1:0]  csel;
  logic [2:0]        state_o;

  logic [DATA_W-1:0] mem [8][NPIX];
  logic [W-1:0]      exp_q[$];
  logic [W-1:0]      exp_e;
  logic [NUM_CH-1:0] cur_mask;
  int vec_cnt  = 0;
  int miss_cnt = 0;
  int wr_run, rd_run, rd_bad;

  pool_layer_engine #(
    .IMG_W(IMG_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W),
    .L0_SEL_BASE(L0), .L1_SEL_BASE(L1), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pool_mode(pool_mode), .ch_mask(ch_mask),
    .busy(busy), .done(done), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel), .state_o(state_o)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bank memories: one-cycle read latency, writes land at the clock edge
  always @(posedge clk) begin
    if (crd) cdata_rd <= mem[csel][caddr_rd];
    if (cwr) mem[csel][caddr_wr] <= cdata_wr;
  end

  // Monitor: every write is popped from the scoreboard; reads must target enabled L0 banks
  always @(negedge clk) begin
    if (!reset) begin
      if (crd) begin
        rd_run++;
        if ((int'(csel) < L0) || (int'(csel) >= L0 + NUM_CH) || !cur_mask[int'(csel) - L0])
          rd_bad++;
      end
      if (cwr) begin
        wr_run++;
        vec_cnt++;
        if (exp_q.size() == 0) begin
          miss_cnt++;
          $display("FAIL write_unexpected: got sel=%0d addr=%0d data=%0h, required no write",
                   csel, caddr_wr, cdata_wr);
        end else begin
          exp_e = exp_q.pop_front();
          if ({csel, caddr_wr, cdata_wr} !== exp_e) begin
            miss_cnt++;
            $display("FAIL write: got sel=%0d addr=%0d data=%0h, required sel=%0d addr=%0d data=%0h",
                     csel, caddr_wr, cdata_wr, exp_e[W-1 -: SEL_W],
                     exp_e[DATA_W +: ADDR_W], exp_e[DATA_W-1:0]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    vec_cnt++;
    if (act !== req) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference model: every enabled channel, windows in row-major order
  task automatic push_expected(input bit mode, input logic [NUM_CH-1:0] mask);
    longint px [4];
    longint v;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (mask[ch]) begin
        for (int r = 0; r < HALF; r++) begin
          for (int c = 0; c < HALF; c++) begin
            px[0] = mem[L0 + ch][(2 * r) * IMG_W + 2 * c];
            px[1] = mem[L0 + ch][(2 * r) * IMG_W + 2 * c + 1];
            px[2] = mem[L0 + ch][(2 * r + 1) * IMG_W + 2 * c];
            px[3] = mem[L0 + ch][(2 * r + 1) * IMG_W + 2 * c + 1];
            if (mode) begin
              v = (px[0] + px[1] + px[2] + px[3] + 2) / 4;
            end else begin
              v = px[0];
              for (int k = 1; k < 4; k++) if (px[k] > v) v = px[k];
            end
            exp_q.push_back({SEL_W'(L1 + ch), ADDR_W'(r * HALF + c), DATA_W'(v)});
          end
        end
      end
    end
  endtask

  function automatic int popcnt(input logic [NUM_CH-1:0] m);
    int n = 0;
    for (int i = 0; i < NUM_CH; i++) n += int'(m[i]);
    return n;
  endfunction

  // One complete run; poke re-asserts start part-way through while busy
  task automatic run(input bit mode, input logic [NUM_CH-1:0] mask, input bit poke);
    int n = 0;
    int en = popcnt(mask);
    push_expected(mode, mask);
    cur_mask = mask;
    wr_run = 0; rd_run = 0; rd_bad = 0;
    @(negedge clk);
    start = 1'b1; pool_mode = mode; ch_mask = mask;
    @(negedge clk);
    start = 1'b0;
    while (busy && n < 2000) begin
      n++;
      if (poke && n == 10) begin start = 1'b1; ch_mask = ~mask; pool_mode = ~mode; end
      if (poke && n == 14) start = 1'b0;
      @(negedge clk);
    end
    check("busy_cycles", n, 1 + en * (HALF * HALF * 7 + 1));
    check("done_pulse", done, 1);
    check("queue_drained", exp_q.size(), 0);
    check("write_count", wr_run, en * HALF * HALF);
    check("read_count", rd_run, en * HALF * HALF * 4);
    check("read_sel_bad", rd_bad, 0);
    @(negedge clk);
    check("idle_after_done", {busy, done, crd, cwr}, 0);
    exp_q.delete();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_crd"}, crd, 0);
    check({tag, "_cwr"}, cwr, 0);
    check({tag, "_caddr_rd"}, caddr_rd, 0);
    check({tag, "_caddr_wr"}, caddr_wr, 0);
    check({tag, "_cdata_wr"}, cdata_wr, 0);
    check({tag, "_csel"}, csel, 0);
    check({tag, "_state"}, state_o, 0);
  endtask

  task automatic fill_random(input int bank);
    for (int i = 0; i < NPIX; i++)
      mem[bank][i] = ($urandom_range(0, 4) == 0) ? ONES : DATA_W'($urandom);
  endtask

  initial begin
    int n;
    int ref_max [4] = '{5, 7, 13, 15};
    int ref_avg [4] = '{3, 5, 11, 13};
    reset = 1'b1; start = 1'b0; pool_mode = 1'b0; ch_mask = '0; cur_mask = '0;
    for (int b = 0; b < 8; b++) for (int i = 0; i < NPIX; i++) mem[b][i] = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;

    // Ramp data, max then average, channel 0 only
    for (int i = 0; i < NPIX; i++) mem[1][i] = DATA_W'(i);
    run(1'b0, 2'b01, 1'b0);
    for (int k = 0; k < 4; k++) check("ramp_max", mem[3][k], ref_max[k]);
    run(1'b1, 2'b01, 1'b0);
    for (int k = 0; k < 4; k++) check("ramp_avg", mem[3][k], ref_avg[k]);

    // All-ones average must not overflow
    for (int i = 0; i < NPIX; i++) mem[1][i] = ONES;
    run(1'b1, 2'b01, 1'b0);
    for (int k = 0; k < 4; k++) check("ones_avg", mem[3][k], ONES);

    // Rounding: {1,2,2,2} -> (7+2)>>2 = 2
    mem[1][0] = 1; mem[1][1] = 2; mem[1][4] = 2; mem[1][5] = 2;
    run(1'b1, 2'b01, 1'b0);
    check("round_half_up", mem[3][0], 2);

    // Channel 1 only: banks 1 and 3 must stay untouched
    fill_random(2);
    for (int i = 0; i < 4; i++) mem[3][i] = 20'h5A5A5;
    run(1'($urandom_range(0, 1)), 2'b10, 1'b0);
    for (int k = 0; k < 4; k++) check("bank3_untouched", mem[3][k], 20'h5A5A5);

    // No channels enabled
    run(1'b0, 2'b00, 1'b0);

    // Random data, modes and masks
    for (int t = 0; t < 8; t++) begin
      fill_random(1);
      fill_random(2);
      run(1'($urandom_range(0, 1)), NUM_CH'($urandom_range(0, 3)), 1'b0);
    end

    // Reset during the third output's READ
    fill_random(1);
    push_expected(1'b0, 2'b01);
    cur_mask = 2'b01; wr_run = 0; rd_run = 0; rd_bad = 0;
    @(negedge clk);
    start = 1'b1; pool_mode = 1'b0; ch_mask = 2'b01;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (wr_run < 2 && n < 500) begin @(negedge clk); n++; end
    while (!crd && n < 500) begin @(negedge clk); n++; end
    check("reset_wait_bound", n < 500, 1);
    reset = 1'b1;
    @(negedge clk);
    check_quiet("midreset");
    exp_q.delete();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("no_write_after_reset", wr_run, 2);
    run(1'b1, 2'b11, 1'b0);

    // start re-asserted while busy is ignored
    fill_random(1);
    fill_random(2);
    run(1'b0, 2'b11, 1'b1);
    repeat (3) @(negedge clk);
    check("no_restart", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
